// File: rtl/pll_rst_pkg.sv
// Package for the PLL reset sequencer.
// Contents:
//   - state_e: 2-bit sequencer state encoding (WAIT_LOCK=0, STABLE=1, HOLD=2, RUN=3).
//   - cnt_width(): counter width able to hold 0 .. max(a, b)-1 (minimum 1 bit).
//   - default cycle-count constants and the widths derived from them.
package pll_rst_pkg;

    typedef enum logic [1:0] {
        StWaitLock = 2'd0,
        StStable   = 2'd1,
        StHold     = 2'd2,
        StRun      = 2'd3
    } state_e;

    localparam int unsigned STATE_W = 2;

    // Width of a counter that only needs to reach max(a, b) - 1.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

    localparam int unsigned DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int unsigned DEF_RST_HOLD_CYCLES    = 16;
    localparam int unsigned DEF_WDT_CYCLES         = 65536;
    localparam int unsigned DEF_PLL_RST_PULSE      = 16;
    localparam int unsigned DEF_CNT_W = cnt_width(DEF_LOCK_STABLE_CYCLES, DEF_RST_HOLD_CYCLES);
    localparam int unsigned DEF_WDT_W = cnt_width(DEF_WDT_CYCLES, DEF_PLL_RST_PULSE);

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset.
// Ports:
//   i_clk   destination clock
//   i_rst_n asynchronous active-low reset; all stages clear to 0
//   i_d     asynchronous input bit
//   o_q     synchronized output (i_d delayed by STAGES rising edges)
module cdc_sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Reset sequencer for the NPU core, clocked by the PLL output clock.
// Holds sys_rst_n low until the synchronized PLL lock flag has been stable for
// LOCK_STABLE_CYCLES and a further RST_HOLD_CYCLES have elapsed, then releases
// it synchronously. Lock loss returns to WAIT_LOCK (counted, saturating); a
// software request in RUN re-enters HOLD only.
// Optional feature macro: PLL_RST_SEQ_WDT_EN -- lock-wait watchdog that pulses
// pll_reset after WDT_CYCLES cycles in WAIT_LOCK. Without it pll_reset is 0.
// Ports:
//   clk           PLL output clock (rising edge)
//   rst_n         asynchronous active-low reset
//   pll_lock      PLL lock flag, asynchronous to clk
//   sw_rst_req    single-cycle software reset request (honoured in RUN only)
//   sys_rst_n     core reset, active-low, registered
//   sys_ready     high while in RUN, registered
//   lock_loss_cnt saturating lock-loss count
//   state_o       current state (WAIT_LOCK=0, STABLE=1, HOLD=2, RUN=3)
//   pll_reset     PLL RESET pin drive
module pll_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned RST_HOLD_CYCLES    = 16,
    parameter int unsigned LOSS_CNT_W         = 8,
    parameter int unsigned WDT_CYCLES         = 65536,
    parameter int unsigned PLL_RST_PULSE      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_lock,
    input  logic                  sw_rst_req,
    output logic                  sys_rst_n,
    output logic                  sys_ready,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
    output logic [STATE_W-1:0]    state_o,
    output logic                  pll_reset
);

    localparam int unsigned CNT_W = cnt_width(LOCK_STABLE_CYCLES, RST_HOLD_CYCLES);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);

    logic                  w_lock_s;
    state_e                r_state;
    state_e                w_state_d;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_d;
    logic                  w_loss_inc;
    logic [LOSS_CNT_W-1:0] r_loss_cnt;
    logic                  r_sys_rst_n;
    logic                  r_sys_ready;

    cdc_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_d     (pll_lock),
        .o_q     (w_lock_s)
    );

    // Next-state and counter logic.
    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt + 1'b1;
        w_loss_inc = 1'b0;
        unique case (r_state)
            StWaitLock: begin
                w_cnt_d = '0;
                if (w_lock_s) begin
                    w_state_d = StStable;
                end
            end
            StStable: begin
                if (!w_lock_s) begin
                    w_state_d  = StWaitLock;
                    w_loss_inc = 1'b1;
                end else if (r_cnt == LOCK_LAST) begin
                    w_state_d = StHold;
                end
            end
            StHold: begin
                if (!w_lock_s) begin
                    w_state_d  = StWaitLock;
                    w_loss_inc = 1'b1;
                end else if (r_cnt == HOLD_LAST) begin
                    w_state_d = StRun;
                end
            end
            StRun: begin
                w_cnt_d = '0;
                // Lock loss takes priority over a coincident software request.
                if (!w_lock_s) begin
                    w_state_d  = StWaitLock;
                    w_loss_inc = 1'b1;
                end else if (sw_rst_req) begin
                    w_state_d = StHold;
                end
            end
            default: begin
                w_state_d = StWaitLock;
                w_cnt_d   = '0;
            end
        endcase
        if (w_state_d != r_state) begin
            w_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StWaitLock;
            r_cnt       <= '0;
            r_loss_cnt  <= '0;
            r_sys_rst_n <= 1'b0;
            r_sys_ready <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (w_loss_inc && (r_loss_cnt != '1)) begin
                r_loss_cnt <= r_loss_cnt + 1'b1;
            end
            // Registered from next state so the outputs track state_o exactly.
            r_sys_rst_n <= (w_state_d == StRun);
            r_sys_ready <= (w_state_d == StRun);
        end
    end

    assign sys_rst_n     = r_sys_rst_n;
    assign sys_ready     = r_sys_ready;
    assign lock_loss_cnt = r_loss_cnt;
    assign state_o       = r_state;

`ifdef PLL_RST_SEQ_WDT_EN
    localparam int unsigned WDT_W = cnt_width(WDT_CYCLES, PLL_RST_PULSE);
    localparam logic [WDT_W-1:0] WDT_LAST   = WDT_W'(WDT_CYCLES - 1);
    localparam logic [WDT_W-1:0] PULSE_LAST = WDT_W'(PLL_RST_PULSE - 1);

    logic [WDT_W-1:0] r_wdt;
    logic [WDT_W-1:0] w_wdt_d;
    logic             r_pll_reset;
    logic             w_pll_reset_d;

    // One counter times both the lock wait and the reset pulse; it restarts
    // from 0 at each phase boundary and whenever WAIT_LOCK is left.
    always_comb begin
        w_wdt_d       = r_wdt + 1'b1;
        w_pll_reset_d = r_pll_reset;
        if ((r_state != StWaitLock) || (w_state_d != StWaitLock)) begin
            w_wdt_d       = '0;
            w_pll_reset_d = 1'b0;
        end else if (r_pll_reset) begin
            if (r_wdt == PULSE_LAST) begin
                w_wdt_d       = '0;
                w_pll_reset_d = 1'b0;
            end
        end else if (r_wdt == WDT_LAST) begin
            w_wdt_d       = '0;
            w_pll_reset_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdt       <= '0;
            r_pll_reset <= 1'b0;
        end else begin
            r_wdt       <= w_wdt_d;
            r_pll_reset <= w_pll_reset_d;
        end
    end

    assign pll_reset = r_pll_reset;
`else
    assign pll_reset = 1'b0;
`endif

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Reset sequencer directly downstream of the 100 MHz rPLL. Runs on the PLL output clock and consumes the PLL's asynchronous lock flag. Holds the NPU core in reset until lock has been stable for a programmable time, then releases a clean, synchronously deasserted reset. Re-asserts reset on lock loss or a software reset request, and counts lock-loss events for debug.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth for `pll_lock`; minimum 2.
- LOCK_STABLE_CYCLES, 1024: consecutive synced-lock cycles required before reset release; ≥1.
- RST_HOLD_CYCLES, 16: cycles reset stays asserted after stability is reached or a software request; ≥1.
- LOSS_CNT_W, 8: width of the lock-loss counter.
- WDT_CYCLES, 65536: lock-wait timeout, used only with the watchdog macro.
- PLL_RST_PULSE, 16: width of the PLL reset pulse, used only with the watchdog macro.

Ports:
- clk  in  1  PLL output clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pll_lock  in  1  PLL lock flag, asynchronous to `clk`.
- sw_rst_req  in  1  synchronous single-cycle software reset request.
- sys_rst_n  out  1  core reset, active-low; asserts asynchronously with `rst_n`, deasserts synchronously.
- sys_ready  out  1  high while in RUN.
- lock_loss_cnt  out  LOSS_CNT_W  saturating count of lock drops.
- state_o  out  2  current state: WAIT_LOCK=0, STABLE=1, HOLD=2, RUN=3.
- pll_reset  out  1  drive for the PLL RESET pin; tied 0 without the watchdog macro.

## Operation
- `lock_s` is `pll_lock` after SYNC_STAGES flops. The flops reset to 0.
- Single counter `cnt`, sized to the larger of LOCK_STABLE_CYCLES and RST_HOLD_CYCLES. It is cleared on every state change.

State machine:
- WAIT_LOCK: if `lock_s`=1, go to STABLE.
- STABLE:
  - `lock_s`=0: go to WAIT_LOCK and increment the loss count.
  - `cnt`==LOCK_STABLE_CYCLES−1: go to HOLD.
  - Otherwise `cnt`++.
- HOLD:
  - `lock_s`=0: go to WAIT_LOCK and increment the loss count.
  - `cnt`==RST_HOLD_CYCLES−1: go to RUN.
  - Otherwise `cnt`++.
- RUN:
  - `lock_s`=0: go to WAIT_LOCK and increment the loss count.
  - Else if `sw_rst_req`: go to HOLD. There is no re-stabilization.

Rules:
- `sw_rst_req` is ignored outside RUN.
- If lock drops and `sw_rst_req` is high in the same cycle in RUN, lock loss wins.
- `lock_loss_cnt` saturates at all-ones. It never wraps.
- Outputs are registered: `sys_rst_n`=1 and `sys_ready`=1 exactly in cycles where `state_o`==RUN.
- Reset values: state WAIT_LOCK, `cnt`=0, `sys_rst_n`=0, `sys_ready`=0, `lock_loss_cnt`=0, `pll_reset`=0, synchronizers 0.
- `rst_n` asserted mid-operation forces all of the above immediately (asynchronously).

## Timing
- `pll_lock` rise to `lock_s` high: SYNC_STAGES edges.
- `lock_s` high to `sys_rst_n` high: 1 + LOCK_STABLE_CYCLES + RST_HOLD_CYCLES edges.
- Lock fall in RUN to `sys_rst_n` low: SYNC_STAGES + 1 edges.
- `sw_rst_req` in RUN to `sys_rst_n` low: 1 edge. Reset then stays low for RST_HOLD_CYCLES cycles.
- Each loss-count increment is visible on the same edge as the transition to WAIT_LOCK.

## Configuration
- Macro: `PLL_RST_SEQ_WDT_EN`.
- Defined: a watchdog counter runs only in WAIT_LOCK.
  - After WDT_CYCLES cycles without lock, `pll_reset` goes high for PLL_RST_PULSE cycles. The state stays WAIT_LOCK.
  - The watchdog then restarts from 0.
  - Leaving WAIT_LOCK clears the watchdog and deasserts `pll_reset`.
- Undefined: no watchdog logic; `pll_reset` is constant 0.

## Structure
- Package `pll_rst_pkg` holds:
  - the state enum typedef and its 2-bit encoding;
  - the width-derivation constants (`$clog2` of the cycle parameters).
- Sub-module `cdc_sync_bit` is the parameterized SYNC_STAGES flop chain with asynchronous active-low reset. It is instantiated once for `pll_lock`.

## Test plan
All scenarios use SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, RST_HOLD_CYCLES=4, WDT_CYCLES=64, PLL_RST_PULSE=4.
- Power-up: release `rst_n`, raise `pll_lock` at edge 0 → `sys_rst_n` rises after edge 15; `state_o` steps 0→1→2→3.
- Glitchy lock: drop `pll_lock` during STABLE (cycle 5) → return to WAIT_LOCK, `lock_loss_cnt`=1, counter restarts; full 8+4 sequence on re-lock.
- Lock loss in RUN: `sys_rst_n` low 3 edges after the fall. Repeat 300 times → `lock_loss_cnt` stays at 255.
- Software reset: `sw_rst_req` pulse in RUN → `sys_rst_n` low for exactly 4 cycles, then high. The same pulse in HOLD causes no change.
- Simultaneous events: `sw_rst_req` in the same cycle that `lock_s` falls in RUN → state WAIT_LOCK (not HOLD), count +1. `rst_n` low mid-HOLD → all outputs at reset values immediately.
- With `PLL_RST_SEQ_WDT_EN` and `pll_lock` held low: `pll_reset` high for cycles 64–67, repeating every 68 cycles. Raising lock during a pulse ends the pulse on the next STABLE entry.
